imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter D_WIDTH, default 8, width of the incoming byte stream.
REQ-002 Parameter I_ADR_WIDTH, default 9, instruction-memory address width.
REQ-003 Parameter I_WIDTH, default 20, single instruction width.
REQ-004 Parameter I_BUFFER_SIZE, default 2, instructions per memory word; word width W = I_BUFFER_SIZE*I_WIDTH (40).
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 load_start  input  1  one-cycle request to begin a load; sampled only in IDLE.
REQ-008 load_base  input  I_ADR_WIDTH  first write address; captured with load_start.
REQ-009 load_len  input  I_ADR_WIDTH+1  number of words to write (0..512); captured with load_start.
REQ-010 byte_in  input  D_WIDTH  stream data.
REQ-011 byte_valid  input  1  byte_in valid.
REQ-012 byte_ready  output  1  loader accepts byte this cycle.
REQ-013 load_abort  input  1  cancel current load.
REQ-014 imem_write_adr  output  I_ADR_WIDTH  write address to instruction buffer.
REQ-015 imem_write  output  1  one-cycle write strobe.
REQ-016 imem_in  output  W  write data.
REQ-017 load_busy  output  1  high in any state except IDLE.
REQ-018 load_done  output  1  one-cycle pulse on successful completion.
REQ-019 load_aborted  output  1  one-cycle pulse when a load is cancelled.

Function
REQ-020 FSM states: IDLE, COLLECT, WRITE, DONE; registered outputs only.
REQ-021 IDLE: load_start=1 captures load_base/load_len, clears byte count; next state COLLECT if load_len!=0, else DONE.
REQ-022 Byte transfer occurs on cycles with byte_valid && byte_ready; byte_ready SHALL equal (state==COLLECT).
REQ-023 Bytes per word NB = ceil(W/D_WIDTH) (5); byte k (0-based) fills bits [k*D_WIDTH +: D_WIDTH], little-endian; bits above W discarded.
REQ-024 Transfer of byte NB-1 in cycle N -> state WRITE in N+1 with imem_write=1, imem_in = assembled word, imem_write_adr = current address; exactly one strobe per word.
REQ-025 byte_ready SHALL be 0 in WRITE and DONE; byte_valid there is not consumed.
REQ-026 After WRITE: address increments by 1 modulo 2^I_ADR_WIDTH (511 -> 0); words_written increments; next state DONE if words_written==load_len, else COLLECT.
REQ-027 DONE: load_done=1 for exactly that cycle; next state IDLE.
REQ-028 load_start while busy SHALL be ignored (no recapture).
REQ-029 load_abort in COLLECT or WRITE: partial word discarded, no further imem_write (abort in WRITE cycle still completes that cycle's strobe), load_aborted pulses next cycle, state -> IDLE; abort in IDLE/DONE ignored.
REQ-030 Simultaneous load_abort and final-byte transfer: abort wins, no write.
REQ-031 imem_write_adr and imem_in hold last values when imem_write=0.

Reset
REQ-032 reset=1 on a clock edge: state IDLE, byte_ready 0, imem_write 0, load_busy 0, load_done 0, load_aborted 0, imem_write_adr 0, imem_in 0, counters 0.
REQ-033 Reset mid-load discards partial word with no write strobe and no done/aborted pulse; reset overrides all inputs.

Structure
REQ-034 Package pat_pkg SHALL hold D_WIDTH/I_ADR_WIDTH/I_WIDTH/I_BUFFER_SIZE defaults, derived W and NB, and the loader state enum.
REQ-035 One sub-module imem_word_assembler (byte counter + word register, clear, last-byte flag); FSM, address and word counters in imem_loader.

Verification
REQ-036 load_start base=0x010 len=2, 10 bytes 0x01..0x0A back-to-back -> writes adr 0x010 data 0x0504030201, adr 0x011 data 0x0A09080706; load_done one cycle after last write.
REQ-037 base=0x1FF len=2 -> writes at 0x1FF then 0x000.
REQ-038 len=0 -> load_busy 1 cycle (DONE), load_done pulse, no imem_write.
REQ-039 byte_valid toggled randomly, len=3 -> exactly 3 writes, data identical to gap-free case, byte_ready 0 on each WRITE cycle.
REQ-040 Abort after 3 bytes of word 1 -> no write for word 1, load_aborted pulse, IDLE; subsequent load base=0x020 len=1 writes correctly.
REQ-041 reset asserted after 7 bytes of len=2 load -> all outputs at reset values next cycle, no further write.

Source files
------------

// File: rtl/pat_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pat_pkg : shared defaults, derived widths and loader state encoding |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package pat_pkg;

  localparam int DEF_D_WIDTH       = 8;
  localparam int DEF_I_ADR_WIDTH   = 9;
  localparam int DEF_I_WIDTH       = 20;
  localparam int DEF_I_BUFFER_SIZE = 2;

  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

  localparam int DEF_W  = DEF_I_BUFFER_SIZE * DEF_I_WIDTH;
  localparam int DEF_NB = ceil_div(DEF_W, DEF_D_WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_WRITE   = 2'd2,
    ST_DONE    = 2'd3
  } loader_state_t;

endpackage
`default_nettype wire

// File: rtl/imem_loader_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | imem_loader_if : load control, byte stream and imem write bundle    |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
interface imem_loader_if
  import pat_pkg::*;
#(
  parameter int D_WIDTH     = DEF_D_WIDTH,
  parameter int I_ADR_WIDTH = DEF_I_ADR_WIDTH,
  parameter int W           = DEF_W
);
  logic                   load_start;
  logic [I_ADR_WIDTH-1:0] load_base;
  logic [I_ADR_WIDTH:0]   load_len;
  logic                   load_abort;
  logic [D_WIDTH-1:0]     byte_in;
  logic                   byte_valid;
  logic                   byte_ready;
  logic [I_ADR_WIDTH-1:0] imem_write_adr;
  logic                   imem_write;
  logic [W-1:0]           imem_in;
  logic                   load_busy;
  logic                   load_done;
  logic                   load_aborted;

  modport master (
    output load_start, load_base, load_len, load_abort, byte_in, byte_valid,
    input  byte_ready, imem_write_adr, imem_write, imem_in,
           load_busy, load_done, load_aborted
  );

  modport slave (
    input  load_start, load_base, load_len, load_abort, byte_in, byte_valid,
    output byte_ready, imem_write_adr, imem_write, imem_in,
           load_busy, load_done, load_aborted
  );
endinterface
`default_nettype wire

// File: rtl/imem_word_assembler.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | imem_word_assembler : packs bytes little-endian into one imem word  |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module imem_word_assembler #(
  parameter int D_WIDTH = 8,
  parameter int W       = 40,
  parameter int NB      = 5
) (
  input  wire logic               clk,
  input  wire logic               reset,
  input  wire logic               clear,
  input  wire logic               byte_en,
  input  wire logic [D_WIDTH-1:0] byte_in,
  output logic      [W-1:0]       word_out,
  output logic                    last_byte
);
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;

  logic [CW-1:0]           r_count;
  logic [NB*D_WIDTH-1:0]   r_word;
  logic [NB*D_WIDTH-1:0]   w_word;

  // The incoming byte is merged combinationally so the caller can capture
  // the complete word on the same edge that consumes the final byte.
  always_comb begin
    w_word = r_word;
    if (byte_en) begin
      w_word[int'(r_count)*D_WIDTH +: D_WIDTH] = byte_in;
    end
  end

  assign word_out  = w_word[W-1:0];
  assign last_byte = (r_count == CW'(NB - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
      r_word  <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (byte_en) begin
      r_count <= last_byte ? '0 : r_count + CW'(1);
      r_word  <= w_word;
    end
  end
endmodule
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | imem_loader : streams bytes into instruction memory words           |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module imem_loader
  import pat_pkg::*;
#(
  parameter int D_WIDTH       = DEF_D_WIDTH,
  parameter int I_ADR_WIDTH   = DEF_I_ADR_WIDTH,
  parameter int I_WIDTH       = DEF_I_WIDTH,
  parameter int I_BUFFER_SIZE = DEF_I_BUFFER_SIZE
) (
  input  wire logic clk,
  input  wire logic reset,
  imem_loader_if.slave bus
);
  localparam int W  = I_BUFFER_SIZE * I_WIDTH;
  localparam int NB = ceil_div(W, D_WIDTH);

  loader_state_t          r_state;
  loader_state_t          w_state_next;
  logic [I_ADR_WIDTH-1:0] r_adr;
  logic [I_ADR_WIDTH:0]   r_len;
  logic [I_ADR_WIDTH:0]   r_words;
  logic [I_ADR_WIDTH:0]   w_words_next;
  logic [I_ADR_WIDTH-1:0] r_imem_adr;
  logic [W-1:0]           r_imem_in;
  logic                   r_aborted;
  logic                   w_xfer;
  logic                   w_abort;
  logic                   w_start;
  logic                   w_clear;
  logic                   w_last_byte;
  logic [W-1:0]           w_asm_word;

  assign w_xfer       = bus.byte_valid && (r_state == ST_COLLECT);
  assign w_abort      = bus.load_abort &&
                        ((r_state == ST_COLLECT) || (r_state == ST_WRITE));
  assign w_start      = bus.load_start && (r_state == ST_IDLE);
  assign w_clear      = w_start || w_abort;
  assign w_words_next = r_words + (I_ADR_WIDTH+1)'(1);

  imem_word_assembler #(
    .D_WIDTH (D_WIDTH),
    .W       (W),
    .NB      (NB)
  ) u_asm (
    .clk       (clk),
    .reset     (reset),
    .clear     (w_clear),
    .byte_en   (w_xfer),
    .byte_in   (bus.byte_in),
    .word_out  (w_asm_word),
    .last_byte (w_last_byte)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (bus.load_start) begin
          w_state_next = (bus.load_len == '0) ? ST_DONE : ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        if (bus.load_abort) begin
          w_state_next = ST_IDLE;
        end else if (w_xfer && w_last_byte) begin
          w_state_next = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (bus.load_abort) begin
          w_state_next = ST_IDLE;
        end else if (w_words_next == r_len) begin
          w_state_next = ST_DONE;
        end else begin
          w_state_next = ST_COLLECT;
        end
      end
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Write address/data are latched when the word completes so they are
  // already valid during the WRITE strobe and hold afterwards.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_adr      <= '0;
      r_len      <= '0;
      r_words    <= '0;
      r_imem_adr <= '0;
      r_imem_in  <= '0;
      r_aborted  <= 1'b0;
    end else begin
      r_aborted <= w_abort;
      if (w_start) begin
        r_adr   <= bus.load_base;
        r_len   <= bus.load_len;
        r_words <= '0;
      end
      if (w_xfer && w_last_byte && !bus.load_abort) begin
        r_imem_adr <= r_adr;
        r_imem_in  <= w_asm_word;
      end
      if (r_state == ST_WRITE) begin
        r_adr   <= r_adr + I_ADR_WIDTH'(1);
        r_words <= w_words_next;
      end
    end
  end

  assign bus.byte_ready     = (r_state == ST_COLLECT);
  assign bus.imem_write     = (r_state == ST_WRITE);
  assign bus.load_busy      = (r_state != ST_IDLE);
  assign bus.load_done      = (r_state == ST_DONE);
  assign bus.load_aborted   = r_aborted;
  assign bus.imem_write_adr = r_imem_adr;
  assign bus.imem_in        = r_imem_in;
endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_imem_loader : directed self-checking bench for imem_loader       |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module tb_imem_loader;
  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;
  int   cyc;

  logic [8:0]  wr_adr[$];
  logic [39:0] wr_dat[$];
  int ready_bad, done_cnt, abort_cnt, busy_cnt, done_cyc, last_wr_cyc;

  imem_loader_if #(.D_WIDTH(8), .I_ADR_WIDTH(9), .W(40)) bus ();

  imem_loader dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (bus.imem_write === 1'b1) begin
      wr_adr.push_back(bus.imem_write_adr);
      wr_dat.push_back(bus.imem_in);
      last_wr_cyc = cyc;
      if (bus.byte_ready !== 1'b0) ready_bad++;
    end
    if (bus.load_done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (bus.load_aborted === 1'b1) abort_cnt++;
    if (bus.load_busy === 1'b1) busy_cnt++;
  end

  task automatic clear_log();
    wr_adr.delete();
    wr_dat.delete();
    ready_bad = 0; done_cnt = 0; abort_cnt = 0; busy_cnt = 0;
    done_cyc = -1; last_wr_cyc = -1;
  endtask

  task automatic start_load(input logic [8:0] base, input logic [9:0] len);
    @(negedge clk);
    bus.load_start = 1'b1;
    bus.load_base  = base;
    bus.load_len   = len;
    @(negedge clk);
    bus.load_start = 1'b0;
  endtask

  task automatic send_stream(input int n, input logic [7:0] first, input bit gaps);
    int i = 0;
    int guard = 0;
    while (i < n && guard < 2000) begin
      @(negedge clk);
      guard++;
      if (gaps && $urandom_range(0, 1) == 0) begin
        bus.byte_valid = 1'b0;
        bus.byte_in    = 8'hEE;
      end else begin
        bus.byte_valid = 1'b1;
        bus.byte_in    = first + 8'(i);
        if (bus.byte_ready === 1'b1) i++;
      end
    end
    if (i < n) begin
      n_cmp++; n_err++;
      $display("FAIL send_stream timeout: sent %0d required %0d", i, n);
    end
  endtask

  task automatic wait_idle();
    int k = 0;
    do begin
      @(negedge clk);
      bus.byte_valid = 1'b0;
      k++;
    end while (bus.load_busy !== 1'b0 && k < 200);
    if (k >= 200) begin
      n_cmp++; n_err++;
      $display("FAIL wait_idle timeout: busy %b required 0", bus.load_busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({bus.byte_ready, bus.imem_write, bus.load_busy, bus.load_done, bus.load_aborted} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_flags: got %b required 00000",
               {bus.byte_ready, bus.imem_write, bus.load_busy, bus.load_done, bus.load_aborted});
    end
    n_cmp++;
    if (bus.imem_write_adr !== 9'h000 || bus.imem_in !== 40'h0) begin
      n_err++;
      $display("FAIL reset_bus: got adr %h data %h required 000/0", bus.imem_write_adr, bus.imem_in);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    clear_log();
    start_load(9'h010, 10'd2);
    send_stream(10, 8'h01, 1'b0);
    wait_idle();
    n_cmp++;
    if (wr_adr.size() != 2) begin
      n_err++;
      $display("FAIL basic_count: got %0d writes required 2", wr_adr.size());
    end else begin
      n_cmp++;
      if (wr_adr[0] !== 9'h010 || wr_dat[0] !== 40'h0504030201) begin
        n_err++;
        $display("FAIL basic_w0: got %h/%h required 010/0504030201", wr_adr[0], wr_dat[0]);
      end
      n_cmp++;
      if (wr_adr[1] !== 9'h011 || wr_dat[1] !== 40'h0A09080706) begin
        n_err++;
        $display("FAIL basic_w1: got %h/%h required 011/0a09080706", wr_adr[1], wr_dat[1]);
      end
    end
    n_cmp++;
    if (done_cnt != 1 || done_cyc != last_wr_cyc + 1) begin
      n_err++;
      $display("FAIL basic_done: got cnt %0d at %0d required 1 at %0d", done_cnt, done_cyc, last_wr_cyc + 1);
    end
  endtask

  task automatic test_wrap();
    clear_log();
    start_load(9'h1FF, 10'd2);
    send_stream(10, 8'h20, 1'b0);
    wait_idle();
    n_cmp++;
    if (wr_adr.size() != 2) begin
      n_err++;
      $display("FAIL wrap_count: got %0d writes required 2", wr_adr.size());
    end else begin
      n_cmp++;
      if (wr_adr[0] !== 9'h1FF || wr_adr[1] !== 9'h000) begin
        n_err++;
        $display("FAIL wrap_adr: got %h,%h required 1ff,000", wr_adr[0], wr_adr[1]);
      end
      n_cmp++;
      if (wr_dat[1] !== 40'h2928272625) begin
        n_err++;
        $display("FAIL wrap_data: got %h required 2928272625", wr_dat[1]);
      end
    end
  endtask

  task automatic test_len_zero();
    clear_log();
    start_load(9'h033, 10'd0);
    wait_idle();
    repeat (2) @(negedge clk);
    n_cmp++;
    if (busy_cnt != 1 || done_cnt != 1 || wr_adr.size() != 0) begin
      n_err++;
      $display("FAIL len0: got busy %0d done %0d writes %0d required 1/1/0",
               busy_cnt, done_cnt, wr_adr.size());
    end
  endtask

  task automatic test_gaps();
    clear_log();
    start_load(9'h100, 10'd3);
    send_stream(15, 8'h01, 1'b1);
    wait_idle();
    n_cmp++;
    if (wr_adr.size() != 3) begin
      n_err++;
      $display("FAIL gaps_count: got %0d writes required 3", wr_adr.size());
    end else begin
      n_cmp++;
      if (wr_dat[0] !== 40'h0504030201 || wr_dat[1] !== 40'h0A09080706 ||
          wr_dat[2] !== 40'h0F0E0D0C0B) begin
        n_err++;
        $display("FAIL gaps_data: got %h %h %h", wr_dat[0], wr_dat[1], wr_dat[2]);
      end
      n_cmp++;
      if (wr_adr[2] !== 9'h102) begin
        n_err++;
        $display("FAIL gaps_adr: got %h required 102", wr_adr[2]);
      end
    end
    n_cmp++;
    if (ready_bad != 0) begin
      n_err++;
      $display("FAIL gaps_ready_in_write: got %0d required 0", ready_bad);
    end
  endtask

  task automatic test_start_while_busy();
    clear_log();
    start_load(9'h060, 10'd1);
    @(negedge clk);
    bus.load_start = 1'b1;
    bus.load_base  = 9'h0AA;
    bus.load_len   = 10'd0;
    @(negedge clk);
    bus.load_start = 1'b0;
    send_stream(5, 8'h41, 1'b0);
    wait_idle();
    n_cmp++;
    if (wr_adr.size() != 1 || done_cnt != 1) begin
      n_err++;
      $display("FAIL busy_start: got writes %0d done %0d required 1/1", wr_adr.size(), done_cnt);
    end else begin
      n_cmp++;
      if (wr_adr[0] !== 9'h060 || wr_dat[0] !== 40'h4544434241) begin
        n_err++;
        $display("FAIL busy_start_w: got %h/%h required 060/4544434241", wr_adr[0], wr_dat[0]);
      end
    end
  endtask

  task automatic test_abort();
    clear_log();
    start_load(9'h040, 10'd2);
    send_stream(8, 8'h01, 1'b0);
    @(negedge clk);
    bus.byte_valid = 1'b0;
    bus.load_abort = 1'b1;
    @(negedge clk);
    bus.load_abort = 1'b0;
    n_cmp++;
    if (bus.load_aborted !== 1'b1 || bus.load_busy !== 1'b0) begin
      n_err++;
      $display("FAIL abort_pulse: got aborted %b busy %b required 1/0", bus.load_aborted, bus.load_busy);
    end
    @(negedge clk);
    n_cmp++;
    if (bus.load_aborted !== 1'b0 || abort_cnt != 1 || done_cnt != 0 || wr_adr.size() != 1) begin
      n_err++;
      $display("FAIL abort_after: got aborted %b cnt %0d done %0d writes %0d required 0/1/0/1",
               bus.load_aborted, abort_cnt, done_cnt, wr_adr.size());
    end

    clear_log();
    start_load(9'h050, 10'd1);
    send_stream(4, 8'h30, 1'b0);
    @(negedge clk);
    bus.byte_valid = 1'b1;
    bus.byte_in    = 8'h34;
    bus.load_abort = 1'b1;
    @(negedge clk);
    bus.load_abort = 1'b0;
    bus.byte_valid = 1'b0;
    wait_idle();
    repeat (2) @(negedge clk);
    n_cmp++;
    if (wr_adr.size() != 0 || abort_cnt != 1 || done_cnt != 0) begin
      n_err++;
      $display("FAIL abort_last_byte: got writes %0d aborted %0d done %0d required 0/1/0",
               wr_adr.size(), abort_cnt, done_cnt);
    end

    clear_log();
    start_load(9'h020, 10'd1);
    send_stream(5, 8'h11, 1'b0);
    wait_idle();
    n_cmp++;
    if (wr_adr.size() != 1 || done_cnt != 1) begin
      n_err++;
      $display("FAIL abort_reload: got writes %0d done %0d required 1/1", wr_adr.size(), done_cnt);
    end else begin
      n_cmp++;
      if (wr_adr[0] !== 9'h020 || wr_dat[0] !== 40'h1514131211) begin
        n_err++;
        $display("FAIL abort_reload_w: got %h/%h required 020/1514131211", wr_adr[0], wr_dat[0]);
      end
    end
  endtask

  task automatic test_reset_midload();
    clear_log();
    start_load(9'h070, 10'd2);
    send_stream(7, 8'h51, 1'b0);
    @(negedge clk);
    reset          = 1'b1;
    bus.byte_valid = 1'b1;
    bus.load_start = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({bus.byte_ready, bus.imem_write, bus.load_busy, bus.load_done, bus.load_aborted} !== 5'b0 ||
        bus.imem_write_adr !== 9'h000 || bus.imem_in !== 40'h0) begin
      n_err++;
      $display("FAIL midload_reset: got flags %b adr %h data %h required 00000/000/0",
               {bus.byte_ready, bus.imem_write, bus.load_busy, bus.load_done, bus.load_aborted},
               bus.imem_write_adr, bus.imem_in);
    end
    reset          = 1'b0;
    bus.byte_valid = 1'b0;
    bus.load_start = 1'b0;
    repeat (10) @(negedge clk);
    n_cmp++;
    if (wr_adr.size() != 1 || done_cnt != 0 || abort_cnt != 0 || bus.load_busy !== 1'b0) begin
      n_err++;
      $display("FAIL midload_after: got writes %0d done %0d aborted %0d busy %b required 1/0/0/0",
               wr_adr.size(), done_cnt, abort_cnt, bus.load_busy);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    cyc   = 0;
    reset = 1'b1;
    bus.load_start = 1'b0;
    bus.load_base  = '0;
    bus.load_len   = '0;
    bus.load_abort = 1'b0;
    bus.byte_in    = '0;
    bus.byte_valid = 1'b0;
    clear_log();

    test_reset();
    test_basic();
    test_wrap();
    test_len_zero();
    test_gaps();
    test_start_while_busy();
    test_abort();
    test_reset_midload();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire
